// File: rtl/fdct_pkg.sv
// Shared constants for the forward 8x8 DCT: widths, shift defaults,
// FSM state encoding and the Q12 cosine basis table.
package fdct_pkg;

  localparam int PIX_W     = 9;   // level-shifted pixel, signed
  localparam int MID_W     = 14;  // row-pass result, signed
  localparam int COEF_W    = 12;  // output coefficient, signed
  localparam int SUM_W     = 28;  // raw dot-product width of the 1-D engine
  localparam int COS_W     = 13;  // Q12 cosine entry, signed
  localparam int ROW_SHIFT = 10;
  localparam int COL_SHIFT = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // COS_Q12[u][x] = round(4096 * c(u)/2 * cos((2x+1)u*pi/16)), half away from zero
  localparam logic signed [COS_W-1:0] COS_Q12 [8][8] = '{
    '{ 13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448},
    '{ 13'sd2009,  13'sd1703,  13'sd1138,  13'sd400,  -13'sd400,  -13'sd1138, -13'sd1703, -13'sd2009},
    '{ 13'sd1892,  13'sd784,  -13'sd784,  -13'sd1892, -13'sd1892, -13'sd784,   13'sd784,   13'sd1892},
    '{ 13'sd1703, -13'sd400,  -13'sd2009, -13'sd1138,  13'sd1138,  13'sd2009,  13'sd400,  -13'sd1703},
    '{ 13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,  13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448},
    '{ 13'sd1138, -13'sd2009,  13'sd400,   13'sd1703, -13'sd1703, -13'sd400,   13'sd2009, -13'sd1138},
    '{ 13'sd784,  -13'sd1892,  13'sd1892, -13'sd784,  -13'sd784,   13'sd1892, -13'sd1892,  13'sd784 },
    '{ 13'sd400,  -13'sd1138,  13'sd1703, -13'sd2009,  13'sd2009, -13'sd1703,  13'sd1138, -13'sd400 }
  };

endpackage

// File: rtl/fdct_1d_8pt.sv
// Combinational 8-point DCT engine: sum[k] = sum_i COS_Q12[k][i] * vec[i].
// Shared by the row and column passes; rounding is left to the parent.
module fdct_1d_8pt
  import fdct_pkg::*;
(
  input  logic signed [MID_W-1:0] vec [8],
  output logic signed [SUM_W-1:0] sum [8]
);

  // Matrix-vector product, one 8-term dot product per output frequency
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      logic signed [SUM_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < 8; i++) begin
        acc = acc + SUM_W'(vec[i]) * SUM_W'(COS_Q12[k][i]);
      end
      sum[k] = acc;
    end
  end

endmodule

// File: rtl/fdct_8x8.sv
// Forward 2-D 8x8 DCT: level shift, row pass into a transpose buffer,
// column pass into the output register, all on one shared 1-D engine.
module fdct_8x8 #(
  parameter int COEF_W    = fdct_pkg::COEF_W,
  parameter int ROW_SHIFT = fdct_pkg::ROW_SHIFT,
  parameter int COL_SHIFT = fdct_pkg::COL_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [511:0]             data_in,
  output logic [64*COEF_W-1:0]     data_out,
  output logic                     m_valid,
  input  logic                     m_ready
);

  localparam int PIX_W = fdct_pkg::PIX_W;
  localparam int MID_W = fdct_pkg::MID_W;
  localparam int SUM_W = fdct_pkg::SUM_W;

  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((1 << (COEF_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-(1 << (COEF_W - 1)));

  fdct_pkg::state_e state;
  logic [2:0]       cnt;

  logic signed [PIX_W-1:0]  pix_p0  [8][8];  // [row][col] level-shifted pixels
  logic signed [MID_W-1:0]  tr_p1   [8][8];  // [u][row] row-pass results
  logic signed [COEF_W-1:0] coef_p2 [8][8];  // [v][u] final coefficients

  logic signed [MID_W-1:0] eng_in  [8];
  logic signed [SUM_W-1:0] eng_sum [8];

  function automatic logic signed [MID_W-1:0] row_round(input logic signed [SUM_W-1:0] s);
    return MID_W'((s + SUM_W'(1 << (ROW_SHIFT - 1))) >>> ROW_SHIFT);
  endfunction

  function automatic logic signed [SUM_W-1:0] col_round(input logic signed [SUM_W-1:0] s);
    return (s + SUM_W'(1 << (COL_SHIFT - 1))) >>> COL_SHIFT;
  endfunction

  function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [SUM_W-1:0] v);
    if (v > SAT_HI)      return COEF_W'(SAT_HI);
    else if (v < SAT_LO) return COEF_W'(SAT_LO);
    else                 return COEF_W'(v);
  endfunction

  assign s_ready = (state == fdct_pkg::ST_IDLE);
  assign m_valid = (state == fdct_pkg::ST_OUT);

  // Block sequencing: accept, 8 row cycles, 8 column cycles, hold until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= fdct_pkg::ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        fdct_pkg::ST_IDLE: if (s_valid) begin
          state <= fdct_pkg::ST_ROW;
          cnt   <= 3'd0;
        end
        fdct_pkg::ST_ROW: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= fdct_pkg::ST_COL;
        end
        fdct_pkg::ST_COL: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= fdct_pkg::ST_OUT;
        end
        fdct_pkg::ST_OUT: if (m_ready) state <= fdct_pkg::ST_IDLE;
        default: state <= fdct_pkg::ST_IDLE;
      endcase
    end
  end

  // ---- p0: input capture with level shift by -128 ----
  // Latch the whole block on the input handshake
  always_ff @(posedge clk) begin
    if (state == fdct_pkg::ST_IDLE && s_valid) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          pix_p0[r][c] <= $signed({1'b0, data_in[(r*8+c)*8 +: 8]}) - 9'sd128;
        end
      end
    end
  end

  // Engine operand select: pixel row during ROW, transposed row during COL
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      eng_in[i] = '0;
      if (state == fdct_pkg::ST_COL) eng_in[i] = tr_p1[cnt][i];
      else                           eng_in[i] = MID_W'(pix_p0[cnt][i]);
    end
  end

  fdct_1d_8pt u_engine (
    .vec (eng_in),
    .sum (eng_sum)
  );

  // ---- p1: row pass, stored transposed so COL reads rows of it ----
  // Row r result for frequency u lands in tr_p1[u][r]
  always_ff @(posedge clk) begin
    if (state == fdct_pkg::ST_ROW) begin
      for (int u = 0; u < 8; u++) begin
        tr_p1[u][cnt] <= row_round(eng_sum[u]);
      end
    end
  end

  // ---- p2: column pass into the output register ----
  // Column c (= horizontal frequency u) writes coefficients v*8+c
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < 8; v++) begin
        for (int u = 0; u < 8; u++) coef_p2[v][u] <= '0;
      end
    end else if (state == fdct_pkg::ST_COL) begin
      for (int v = 0; v < 8; v++) begin
        coef_p2[v][cnt] <= sat_coef(col_round(eng_sum[v]));
      end
    end
  end

  // Flatten the coefficient grid in natural row-major order
  always_comb begin
    data_out = '0;
    for (int v = 0; v < 8; v++) begin
      for (int u = 0; u < 8; u++) begin
        data_out[(v*8+u)*COEF_W +: COEF_W] = coef_p2[v][u];
      end
    end
  end

endmodule

// File: tb/tb_fdct_8x8.sv
// Bench for fdct_8x8: directed blocks, output stall, mid-block reset and
// a randomized back-to-back run, scored against a floating-point-derived
// Q12 reference model.
module tb_fdct_8x8;

  localparam int  CW      = 12;
  localparam int  ROW_SH  = 10;
  localparam int  COL_SH  = 14;
  localparam real PI      = 3.14159265358979323846;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid;
  logic           s_ready;
  logic [511:0]   data_in;
  logic [767:0]   data_out;
  logic           m_valid;
  logic           m_ready;

  int             n_checks = 0;
  int             n_err    = 0;
  logic [767:0]   sb[$];
  int             n_out    = 0;
  longint         cyc      = 0;
  longint         last_out = -1;

  always #5 clk = ~clk;

  fdct_8x8 #(.COEF_W(CW), .ROW_SHIFT(ROW_SH), .COL_SHIFT(COL_SH)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .data_out (data_out),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: cosine table from $cos, exact integer row/column passes
  function automatic logic [767:0] ref_dct(input logic [511:0] blk);
    int          ctab [8][8];
    longint      mid  [8][8];
    longint      s, o;
    real         cu, v;
    logic [7:0]  b;
    logic [767:0] res;
    for (int u = 0; u < 8; u++) begin
      for (int x = 0; x < 8; x++) begin
        cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        v  = 2048.0 * cu * $cos(real'((2*x+1)*u) * PI / 16.0);
        ctab[u][x] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
      end
    end
    for (int r = 0; r < 8; r++) begin
      for (int u = 0; u < 8; u++) begin
        s = 0;
        for (int x = 0; x < 8; x++) begin
          b = blk[(r*8+x)*8 +: 8];
          s += longint'(ctab[u][x]) * (longint'(b) - 128);
        end
        mid[u][r] = (s + (64'sd1 <<< (ROW_SH-1))) >>> ROW_SH;
      end
    end
    res = '0;
    for (int c = 0; c < 8; c++) begin
      for (int vv = 0; vv < 8; vv++) begin
        s = 0;
        for (int y = 0; y < 8; y++) s += longint'(ctab[vv][y]) * mid[c][y];
        o = (s + (64'sd1 <<< (COL_SH-1))) >>> COL_SH;
        if (o > 2047)  o = 2047;
        if (o < -2048) o = -2048;
        res[(vv*8+c)*CW +: CW] = o[11:0];
      end
    end
    return res;
  endfunction

  // Output monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      check("block_expected", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) check("block_data", data_out, sb.pop_front());
      if (last_out >= 0) check("block_spacing", ((cyc - last_out) >= 18), 1'b1);
      last_out <= cyc;
      n_out    <= n_out + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [511:0] blk, input bit push, output int waited);
    s_valid = 1'b1;
    data_in = blk;
    waited  = 0;
    @(negedge clk);
    while (!s_ready && waited < 200) begin
      @(posedge clk); #1;
      @(negedge clk);
      waited++;
    end
    check("accept_in_time", s_ready, 1'b1);
    if (s_ready && push) sb.push_back(ref_dct(blk));
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(input int budget);
    int t = 0;
    while (!m_valid && t < budget) begin
      step();
      t++;
    end
    check("mvalid_in_time", m_valid, 1'b1);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin
      step();
      t++;
    end
    check("drained", (sb.size() == 0), 1'b1);
  endtask

  initial begin
    logic [511:0] blk;
    logic [511:0] blk_c;
    logic [767:0] snap;
    logic [511:0] rb [20];
    int           w, lat, mv_seen, sent, base;

    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; data_in = '0;
    repeat (3) step();
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_data_out", data_out, '0);
    rst = 1'b0;
    m_ready = 1'b1;
    step();

    // Flat mid-grey: everything zero, latency measured in cycles after acceptance
    blk = {64{8'd128}};
    send_block(blk, 1'b1, w);
    lat = 1;
    while (!m_valid && lat < 40) begin
      step();
      lat++;
    end
    check("latency", lat, 17);
    drain(40);

    // Flat white
    blk = {64{8'd255}};
    send_block(blk, 1'b1, w);
    wait_mvalid(40);
    check("dc_white", data_out[11:0], 12'd1016);
    check("ac_white", data_out[767:12], '0);
    drain(40);

    // Flat black
    blk = '0;
    send_block(blk, 1'b1, w);
    wait_mvalid(40);
    check("dc_black", data_out[11:0], 12'hC00);
    check("ac_black", data_out[767:12], '0);
    drain(40);

    // Single bright pixel at (0,0)
    blk = {64{8'd128}};
    blk[7:0] = 8'd255;
    send_block(blk, 1'b1, w);
    wait_mvalid(40);
    check("dc_impulse", data_out[11:0], 12'd16);
    drain(40);

    // Output stall with a competing input block
    m_ready = 1'b0;
    for (int k = 0; k < 64; k++) blk[k*8 +: 8] = 8'($urandom);
    for (int k = 0; k < 64; k++) blk_c[k*8 +: 8] = 8'($urandom);
    send_block(blk, 1'b1, w);
    wait_mvalid(40);
    snap = data_out;
    s_valid = 1'b1;
    data_in = blk_c;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold", data_out, snap);
      check("stall_s_ready", s_ready, 1'b0);
      check("stall_m_valid", m_valid, 1'b1);
    end
    m_ready = 1'b1;
    step();
    check("idle_after_out", s_ready, 1'b1);
    send_block(blk_c, 1'b1, w);
    check("accept_first_idle", w, 0);
    drain(40);

    // Reset during the fifth ROW cycle discards the block
    for (int k = 0; k < 64; k++) blk[k*8 +: 8] = 8'($urandom);
    send_block(blk, 1'b0, w);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_s_ready", s_ready, 1'b1);
    check("abort_m_valid", m_valid, 1'b0);
    mv_seen = 0;
    repeat (30) begin
      step();
      if (m_valid) mv_seen++;
    end
    check("abort_no_output", mv_seen, 0);
    for (int k = 0; k < 64; k++) blk[k*8 +: 8] = 8'($urandom);
    send_block(blk, 1'b1, w);
    drain(60);

    // Back-to-back random blocks with random output back-pressure
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 64; k++) rb[i][k*8 +: 8] = 8'($urandom);
    end
    for (int k = 0; k < 64; k++) rb[0][k*8 +: 8] = ((k + k/8) % 2 == 0) ? 8'd255 : 8'd0;
    rb[1] = '0;
    sent = 0;
    base = n_out;
    for (int t = 0; t < 3000 && (n_out - base) < 20; t++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      s_valid = (sent < 20);
      if (sent < 20) data_in = rb[sent];
      @(negedge clk);
      if (s_valid && s_ready) begin
        sb.push_back(ref_dct(rb[sent]));
        sent++;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check("random_all_out", n_out - base, 20);
    check("random_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
